// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query and MDU control bundle for hazard_scoreboard.
// The master drives the decode/execute side; the slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TNEW_W  = 2,
  parameter int unsigned SEL_W   = 2
);
  logic                       flush;
  logic [NUM_SRC*REG_W-1:0]   D_src_reg;
  logic [NUM_SRC*TNEW_W-1:0]  D_src_tuse;
  logic [NUM_SRC-1:0]         D_src_valid;
  logic                       D_wr_en;
  logic [REG_W-1:0]           D_wr_reg;
  logic [TNEW_W-1:0]          D_tnew;
  logic                       D_is_mdu;
  logic                       E_md_start;
  logic                       E_md_is_div;
  logic                       stall;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       md_busy;

  modport master (
    output flush, D_src_reg, D_src_tuse, D_src_valid, D_wr_en, D_wr_reg, D_tnew, D_is_mdu,
           E_md_start, E_md_is_div,
    input  stall, fwd_sel, md_busy
  );

  modport slave (
    input  flush, D_src_reg, D_src_tuse, D_src_valid, D_wr_en, D_wr_reg, D_tnew, D_is_mdu,
           E_md_start, E_md_is_div,
    output stall, fwd_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard scoreboard: tracks in-flight GPR writes per post-decode stage and
// derives the D-stage stall, per-operand forward selects and MDU busy state.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned TNEW_W      = 2,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // Index s holds stage s+1 (s = 0 is the stage right after D).
  logic [NUM_STAGES-1:0] valid_q;
  logic [REG_W-1:0]      reg_q  [NUM_STAGES];
  logic [TNEW_W-1:0]     tnew_q [NUM_STAGES];
  logic [CntW-1:0]       md_cnt_q;

  logic                     md_busy_c;
  logic                     src_stall_c;
  logic                     stall_c;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;

  always_comb begin : p_match
    logic              hit;
    logic [TNEW_W-1:0] hit_tnew;
    logic [SEL_W-1:0]  hit_sel;
    logic [REG_W-1:0]  src;
    logic [TNEW_W-1:0] tuse;
    src_stall_c = 1'b0;
    fwd_sel_c   = '0;
    hit         = 1'b0;
    hit_tnew    = '0;
    hit_sel     = '0;
    src         = '0;
    tuse        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src      = bus.D_src_reg[i*REG_W +: REG_W];
      tuse     = bus.D_src_tuse[i*TNEW_W +: TNEW_W];
      hit      = 1'b0;
      hit_tnew = '0;
      hit_sel  = '0;
      // Walk oldest to youngest so the youngest match overwrites older ones.
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (bus.D_src_valid[i] && valid_q[k] && (reg_q[k] == src) && (src != '0)) begin
          hit      = 1'b1;
          hit_tnew = tnew_q[k];
          hit_sel  = SEL_W'(k + 1);
        end
      end
      if (hit && (hit_tnew > tuse)) begin
        src_stall_c = 1'b1;
      end
      if (hit && (hit_tnew == '0)) begin
        fwd_sel_c[i*SEL_W +: SEL_W] = hit_sel;
      end
    end
  end

  always_comb begin
    md_busy_c = bus.E_md_start || (md_cnt_q != '0);
    stall_c   = src_stall_c || (bus.D_is_mdu && md_busy_c);
  end

  assign bus.stall   = stall_c;
  assign bus.fwd_sel = fwd_sel_c;
  assign bus.md_busy = md_busy_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      md_cnt_q <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        reg_q[s]  <= '0;
        tnew_q[s] <= '0;
      end
    end else begin
      if (bus.flush) begin
        valid_q <= '0;
      end else begin
        for (int s = NUM_STAGES - 1; s >= 1; s--) begin
          valid_q[s] <= valid_q[s-1];
          reg_q[s]   <= reg_q[s-1];
          tnew_q[s]  <= (tnew_q[s-1] == '0) ? '0 : tnew_q[s-1] - 1'b1;
        end
        if (stall_c) begin
          valid_q[0] <= 1'b0;
          reg_q[0]   <= '0;
          tnew_q[0]  <= '0;
        end else begin
          valid_q[0] <= bus.D_wr_en && (bus.D_wr_reg != '0);
          reg_q[0]   <= bus.D_wr_reg;
          tnew_q[0]  <= bus.D_tnew;
        end
      end
      // An in-flight mult/div completes regardless of flush.
      if (bus.E_md_start) begin
        md_cnt_q <= bus.E_md_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
      end else if (md_cnt_q != '0) begin
        md_cnt_q <= md_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a cycle-history reference model.
module tb_hazard_scoreboard;
  localparam int NS   = 3;
  localparam int NSRC = 2;
  localparam int RW   = 5;
  localparam int TW   = 2;
  localparam int SW   = 2;
  localparam int MULC = 5;
  localparam int DIVC = 10;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_SRC(NSRC), .REG_W(RW), .TNEW_W(TW), .SEL_W(SW)) bus ();

  hazard_scoreboard #(
    .NUM_STAGES (NS),
    .NUM_SRC    (NSRC),
    .REG_W      (RW),
    .TNEW_W     (TW),
    .SEL_W      (SW),
    .MULT_CYCLES(MULC),
    .DIV_CYCLES (DIVC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: what entered stage 1 at the end of each cycle, plus kill/start history.
  bit ent_valid [MAXC];
  int ent_reg   [MAXC];
  int ent_tnew  [MAXC];
  int last_kill  = -1;
  int last_mdrst = -1;
  int last_start = -1;
  int start_len  = 0;
  int t          = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.flush       = 1'b0;
    bus.D_src_reg   = '0;
    bus.D_src_tuse  = '0;
    bus.D_src_valid = '0;
    bus.D_wr_en     = 1'b0;
    bus.D_wr_reg    = '0;
    bus.D_tnew      = '0;
    bus.D_is_mdu    = 1'b0;
    bus.E_md_start  = 1'b0;
    bus.E_md_is_div = 1'b0;
  endtask

  task automatic set_src(input int i, input int r, input int tuse, input bit v);
    bus.D_src_reg[i*RW +: RW]  = r[RW-1:0];
    bus.D_src_tuse[i*TW +: TW] = tuse[TW-1:0];
    bus.D_src_valid[i]         = v;
  endtask

  task automatic set_wr(input bit en, input int r, input int tnew);
    bus.D_wr_en  = en;
    bus.D_wr_reg = r[RW-1:0];
    bus.D_tnew   = tnew[TW-1:0];
  endtask

  // Compare one cycle against the model, record it, then advance past the clock edge.
  task automatic step();
    bit exp_stall;
    bit exp_busy;
    int exp_sel;
    int src;
    int tuse;
    int tn;
    int c;
    bit found;
    @(negedge clk);
    if (t >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", t, MAXC);
      $fatal(1);
    end
    if (reset) begin
      ent_valid[t] = 1'b0;
      last_kill    = t;
      last_mdrst   = t;
    end else begin
      exp_busy  = bus.E_md_start ||
                  (last_start > last_mdrst && (t - last_start) <= start_len);
      exp_stall = bus.D_is_mdu && exp_busy;
      for (int i = 0; i < NSRC; i++) begin
        src     = int'(bus.D_src_reg[i*RW +: RW]);
        tuse    = int'(bus.D_src_tuse[i*TW +: TW]);
        exp_sel = 0;
        found   = 1'b0;
        if (bus.D_src_valid[i] && src != 0) begin
          for (int k = 1; k <= NS && !found; k++) begin
            c = t - k;
            if (c > last_kill && ent_valid[c] && ent_reg[c] == src) begin
              found = 1'b1;
              tn    = (ent_tnew[c] > k - 1) ? ent_tnew[c] - (k - 1) : 0;
              if (tn > tuse) exp_stall = 1'b1;
              if (tn == 0) exp_sel = k;
            end
          end
        end
        check_eq($sformatf("t%0d fwd_sel[%0d]", t, i), 32'(bus.fwd_sel[i*SW +: SW]),
                 32'(exp_sel));
      end
      check_eq($sformatf("t%0d stall", t), 32'(bus.stall), 32'(exp_stall));
      check_eq($sformatf("t%0d md_busy", t), 32'(bus.md_busy), 32'(exp_busy));
      ent_valid[t] = !exp_stall && bus.D_wr_en && (bus.D_wr_reg != '0);
      ent_reg[t]   = int'(bus.D_wr_reg);
      ent_tnew[t]  = int'(bus.D_tnew);
      if (bus.flush) last_kill = t;
      if (bus.E_md_start) begin
        last_start = t;
        start_len  = bus.E_md_is_div ? DIVC : MULC;
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 5;
      2:       return 8;
      3:       return 9;
      4:       return 10;
      default: return int'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    set_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check_eq("reset stall", 32'(bus.stall), 32'd0);
    check_eq("reset fwd_sel", 32'(bus.fwd_sel), 32'd0);
    check_eq("reset md_busy", 32'(bus.md_busy), 32'd0);

    // Load-use: writer then dependent reader held in D.
    set_wr(1, 8, 2); step();
    set_idle(); set_src(0, 8, 1, 1);
    repeat (4) step();

    // ALU chain, tuse=0 then tuse=1 followed by aging into W.
    set_idle(); set_wr(1, 9, 1); step();
    set_idle(); set_src(1, 9, 0, 1);
    repeat (3) step();
    set_idle(); set_wr(1, 9, 1); step();
    set_idle(); set_src(0, 9, 1, 1);
    repeat (4) step();

    // Shadowing by a younger non-ready write, then $0 destination.
    set_idle(); set_wr(1, 10, 0); step();
    set_idle(); step();
    set_wr(1, 10, 1); step();
    set_idle(); set_src(0, 10, 0, 1); step(); step();
    set_idle(); set_wr(1, 0, 1); step();
    set_idle(); set_src(0, 0, 0, 1); set_src(1, 0, 0, 1); step();

    // Divide with MDU-dependent D instruction, flush mid-way.
    set_idle(); bus.E_md_start = 1; bus.E_md_is_div = 1; bus.D_is_mdu = 1; step();
    bus.E_md_start = 0; bus.E_md_is_div = 0;
    for (int i = 0; i < 12; i++) begin
      bus.flush = (i == 3);
      step();
    end
    set_idle(); bus.E_md_start = 1; bus.D_is_mdu = 1; step();
    bus.E_md_start = 0;
    repeat (7) step();

    // Flush with all stages valid on $5.
    set_idle(); set_wr(1, 5, 0);
    repeat (3) step();
    set_idle(); bus.flush = 1; step();
    bus.flush = 0; set_src(0, 5, 0, 1); step();
    // Flush coinciding with a stall.
    set_idle(); set_wr(1, 6, 3); step();
    set_idle(); set_src(0, 6, 0, 1); set_wr(1, 6, 0); bus.flush = 1; step();
    bus.flush = 0; repeat (3) step();

    // Reset mid-sequence with live entries.
    set_idle(); set_wr(1, 8, 0); step(); step();
    reset = 1; step();
    reset = 0; set_idle(); set_src(0, 8, 0, 1); step(); step();

    // Randomised traffic.
    for (int n = 0; n < 2500; n++) begin
      reset           = ($urandom_range(0, 149) == 0);
      bus.flush       = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < NSRC; i++) begin
        set_src(i, pick_reg(), int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end
      set_wr($urandom_range(0, 3) != 0, pick_reg(), int'($urandom_range(0, 3)));
      bus.D_is_mdu    = ($urandom_range(0, 7) == 0);
      bus.E_md_start  = ($urandom_range(0, 19) == 0);
      bus.E_md_is_div = $urandom_range(0, 1);
      step();
    end
    reset = 0;
    set_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
